clk_gate_sequencer: RTL and testbench

Controller for the clock/reset manager in a single `clk_in` domain. It decides when the processor clock-gate enable (`en_clk_div8`) is asserted and when the processor reset (`proc_rst_n`) is released. Every change is aligned to the low phase of `clk_div8`, so the gated `clk_div8_proc` never carries a truncated pulse. It also provides a halt/resume handshake for the debug/power controller, plus a wake path.

---
 rtl/clk_gate_sequencer.sv | 149 ++++++++++++++
 tb/tb_clk_gate_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/clk_gate_sequencer.sv
// Processor clock-gate / reset-release sequencer, with every enable change aligned to the clk_div8 low phase.
// Define CLK_GATE_SEQ_WDOG_EN to add the phase-alignment watchdog and the sticky wdog_err flag.
module clk_gate_sequencer #(
  parameter int unsigned BOOT_PERIODS = 4
`ifdef CLK_GATE_SEQ_WDOG_EN
  , parameter int unsigned WDOG_CYCLES = 16
`endif
) (
  input  logic       clk_in,
  input  logic       rst_sync_n,
  input  logic       clk_div8,
  input  logic       halt_req,
  input  logic       wake_irq,
  output logic       en_clk_div8,
  output logic       proc_rst_n,
  output logic       halt_ack,
  output logic [2:0] state,
  output logic [7:0] halt_cnt,
  output logic       wdog_err
);

  typedef enum logic [2:0] {
    BOOT_EN     = 3'd0,
    BOOT_CNT    = 3'd1,
    RUN         = 3'd2,
    HALT_WAIT   = 3'd3,
    HALTED      = 3'd4,
    RESUME_WAIT = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       d8_q;
  logic       en_q, en_d;
  logic       prst_q, prst_d;
  logic       rearm_q, rearm_d;
  logic [7:0] bootCnt_q, bootCnt_d;
  logic [7:0] haltCnt_q, haltCnt_d;
  logic       fe;
  logic       adv;

  // A falling edge of clk_div8 seen here means the next clk_in edge lies inside its low phase.
  assign fe = d8_q & ~clk_div8;

`ifdef CLK_GATE_SEQ_WDOG_EN
  logic [15:0] wdogCnt_q, wdogCnt_d;
  logic        wdogErr_q, wdogErr_d;
  logic        waiting;
  logic        wdogFire;

  assign waiting   = (state_q == BOOT_EN) || (state_q == HALT_WAIT) || (state_q == RESUME_WAIT);
  assign wdogFire  = waiting && !fe && (wdogCnt_q == 16'(WDOG_CYCLES - 1));
  assign adv       = fe | wdogFire;
  assign wdogCnt_d = (waiting && !adv) ? wdogCnt_q + 16'd1 : 16'd0;
  assign wdogErr_d = wdogErr_q | wdogFire;
  assign wdog_err  = wdogErr_q;

  always_ff @(posedge clk_in) begin
    if (!rst_sync_n) begin
      wdogCnt_q <= 16'd0;
      wdogErr_q <= 1'b0;
    end else begin
      wdogCnt_q <= wdogCnt_d;
      wdogErr_q <= wdogErr_d;
    end
  end
`else
  assign adv      = fe;
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_sync_n) begin
      state_q   <= BOOT_EN;
      d8_q      <= 1'b0;
      en_q      <= 1'b0;
      prst_q    <= 1'b0;
      rearm_q   <= 1'b1;
      bootCnt_q <= 8'd0;
      haltCnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      d8_q      <= clk_div8;
      en_q      <= en_d;
      prst_q    <= prst_d;
      rearm_q   <= rearm_d;
      bootCnt_q <= bootCnt_d;
      haltCnt_q <= haltCnt_d;
    end
  end

  // A wake-forced resume clears rearm, so a still-held halt_req cannot re-halt until it drops once.
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    prst_d    = prst_q;
    bootCnt_d = bootCnt_q;
    haltCnt_d = haltCnt_q;
    rearm_d   = halt_req ? rearm_q : 1'b1;
    case (state_q)
      BOOT_EN: begin
        if (adv) begin
          en_d      = 1'b1;
          bootCnt_d = 8'd0;
          state_d   = BOOT_CNT;
        end
      end
      BOOT_CNT: begin
        if (fe) begin
          if (bootCnt_q == 8'(BOOT_PERIODS - 1)) begin
            prst_d  = 1'b1;
            state_d = RUN;
          end else begin
            bootCnt_d = bootCnt_q + 8'd1;
          end
        end
      end
      RUN: begin
        if (halt_req && rearm_q) state_d = HALT_WAIT;
      end
      HALT_WAIT: begin
        if (adv) begin
          en_d    = 1'b0;
          state_d = HALTED;
          if (haltCnt_q != 8'hFF) haltCnt_d = haltCnt_q + 8'd1;
        end
      end
      HALTED: begin
        if (wake_irq || !halt_req) begin
          state_d = RESUME_WAIT;
          if (wake_irq) rearm_d = 1'b0;
        end
      end
      RESUME_WAIT: begin
        if (adv) begin
          en_d    = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT_EN;
    endcase
  end

  assign en_clk_div8 = en_q;
  assign proc_rst_n  = prst_q;
  assign halt_ack    = (state_q == HALTED);
  assign state       = state_q;
  assign halt_cnt    = haltCnt_q;

endmodule

// File: tb/tb_clk_gate_sequencer.sv
// Randomized bench for clk_gate_sequencer against a behavioural cycle model of the sequencing rules.
module tb_clk_gate_sequencer;

  localparam int BOOT_P = 4;
`ifdef CLK_GATE_SEQ_WDOG_EN
  localparam int WDOG = 16;
`endif
  localparam int S_BOOT_EN = 0, S_BOOT_CNT = 1, S_RUN = 2, S_HALT_WAIT = 3, S_HALTED = 4, S_RESUME_WAIT = 5;

  logic       clk_in = 1'b0;
  logic       rst_sync_n = 1'b0;
  logic       clk_div8 = 1'b0;
  logic       halt_req = 1'b0;
  logic       wake_irq = 1'b0;
  logic       en_clk_div8, proc_rst_n, halt_ack, wdog_err;
  logic [2:0] state;
  logic [7:0] halt_cnt;

  clk_gate_sequencer dut (
    .clk_in(clk_in), .rst_sync_n(rst_sync_n), .clk_div8(clk_div8),
    .halt_req(halt_req), .wake_irq(wake_irq), .en_clk_div8(en_clk_div8),
    .proc_rst_n(proc_rst_n), .halt_ack(halt_ack), .state(state),
    .halt_cnt(halt_cnt), .wdog_err(wdog_err)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, failures = 0, cyc = 0;
  int divCnt = 0;
  bit stuck = 0;
  logic d8Prev = 1'b0;

  int mState = 0, mCnt = 0, mPeriods = 0;
  bit mEn = 0, mRst = 0, mErr = 0, mRearm = 1, mPrevDiv = 0, mFire = 0;
`ifdef CLK_GATE_SEQ_WDOG_EN
  int mWd = 0;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      if (failures <= 30)
        $display("[TB] FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, observed, expected);
    end
  endtask

  // Advances the reference model by one clk_in edge using the inputs currently applied.
  task automatic modelStep();
    bit fe, go, waitSt, wasHalted;
    mFire = 0;
    if (!rst_sync_n) begin
      mState = S_BOOT_EN; mEn = 0; mRst = 0; mCnt = 0; mErr = 0;
      mRearm = 1; mPrevDiv = 0; mPeriods = 0;
`ifdef CLK_GATE_SEQ_WDOG_EN
      mWd = 0;
`endif
    end else begin
      fe = mPrevDiv && !clk_div8;
      waitSt = (mState == S_BOOT_EN) || (mState == S_HALT_WAIT) || (mState == S_RESUME_WAIT);
      go = fe;
`ifdef CLK_GATE_SEQ_WDOG_EN
      if (waitSt && !fe && mWd == WDOG - 1) begin
        go = 1; mFire = 1; mErr = 1;
      end
      mWd = (waitSt && !go) ? mWd + 1 : 0;
`endif
      wasHalted = (mState == S_HALTED);
      case (mState)
        S_BOOT_EN:     if (go) begin mEn = 1; mPeriods = 0; mState = S_BOOT_CNT; end
        S_BOOT_CNT:    if (fe) begin
                         mPeriods++;
                         if (mPeriods == BOOT_P) begin mRst = 1; mState = S_RUN; end
                       end
        S_RUN:         if (halt_req && mRearm) mState = S_HALT_WAIT;
        S_HALT_WAIT:   if (go) begin mEn = 0; mState = S_HALTED; if (mCnt < 255) mCnt++; end
        S_HALTED:      if (wake_irq || !halt_req) mState = S_RESUME_WAIT;
        S_RESUME_WAIT: if (go) begin mEn = 1; mState = S_RUN; end
        default:       mState = S_BOOT_EN;
      endcase
      if (wasHalted && wake_irq) mRearm = 0;
      else if (!halt_req) mRearm = 1;
      mPrevDiv = clk_div8;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit hr, input bit wk);
    logic prevEn, prevRst;
    logic [31:0] expV, obsV;
    rst_sync_n = rst;
    halt_req   = hr;
    wake_irq   = wk;
    clk_div8   = stuck ? 1'b1 : ((divCnt % 8) < 4);
    prevEn  = en_clk_div8;
    prevRst = proc_rst_n;
    modelStep();
    @(posedge clk_in);
    #1;
    cyc++;
    expV = {17'd0, mErr, 8'(mCnt), 3'(mState), (mState == S_HALTED), mRst, mEn};
    obsV = {17'd0, wdog_err, halt_cnt, state, halt_ack, proc_rst_n, en_clk_div8};
    checkOutput("outs", obsV, expV);
    if (rst && !mFire && (en_clk_div8 !== prevEn || proc_rst_n !== prevRst))
      checkOutput("align", {30'd0, d8Prev, clk_div8}, 32'd2);
    d8Prev = clk_div8;
    divCnt++;
  endtask

  initial begin
    int enRiseCyc;
    int n;
    bit hr;
    bit done;
    divCnt = $urandom_range(0, 7);

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0);
    checkOutput("rstOuts", {25'd0, en_clk_div8, proc_rst_n, halt_ack, state}, 32'd0);

    // Boot with halt_req held high throughout; it must be ignored until RUN.
    enRiseCyc = -1;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      applyStimulus(1, 1, 0);
      if (en_clk_div8 === 1'b1 && enRiseCyc < 0) enRiseCyc = cyc;
      if (proc_rst_n === 1'b1) done = 1;
    end
    if (!done) checkOutput("bootTimeout", 32'd0, 32'd1);
    else checkOutput("bootGap", 32'(cyc - enRiseCyc), 32'd32);
    for (int i = 0; i < 30; i++) applyStimulus(1, 1, 0);
    checkOutput("haltAck", {31'd0, halt_ack}, 32'd1);
    checkOutput("haltCnt1", {24'd0, halt_cnt}, 32'd1);

    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0);
    checkOutput("resumeEn", {30'd0, en_clk_div8, halt_ack}, 32'd2);

    // Wake while the request stays held: resume, no re-halt until halt_req drops once.
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 1);
    for (int i = 0; i < 40; i++) applyStimulus(1, 1, 0);
    checkOutput("noRehalt", {29'd0, state}, 32'd2);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0);
    checkOutput("reHaltCnt", {24'd0, halt_cnt}, 32'd3);

    // Reset landing in HALT_WAIT.
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      applyStimulus(1, 1, 0);
      if (state === 3'd3) done = 1;
    end
    if (!done) checkOutput("haltWaitTimeout", 32'd0, 32'd1);
    applyStimulus(0, 1, 0);
    checkOutput("midRst", {23'd0, wdog_err, halt_cnt, en_clk_div8, proc_rst_n, halt_ack, state}, 32'd0);
    for (int i = 0; i < 60; i++) applyStimulus(1, 0, 0);
    checkOutput("reboot", {31'd0, proc_rst_n}, 32'd1);

    // Random traffic, including occasional resets.
    hr = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) hr = ~hr;
      if ($urandom_range(0, 499) == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) applyStimulus(0, hr, 0);
      end else begin
        applyStimulus(1, hr, ($urandom_range(0, 24) == 0));
      end
    end

    // Enough halts to saturate the counter.
    applyStimulus(0, 0, 0);
    for (int i = 0; i < 60; i++) applyStimulus(1, 0, 0);
    for (int h = 0; h < 280; h++) begin
      for (int i = 0; i < 15; i++) applyStimulus(1, 1, 0);
      for (int i = 0; i < 15; i++) applyStimulus(1, 0, 0);
    end
    checkOutput("satCnt", {24'd0, halt_cnt}, 32'd255);

    // clk_div8 stuck high while waiting for the first aligned slot.
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    stuck = 1;
    for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0);
`ifdef CLK_GATE_SEQ_WDOG_EN
    checkOutput("wdogErr", {31'd0, wdog_err}, 32'd1);
    checkOutput("wdogEn", {31'd0, en_clk_div8}, 32'd1);
`else
    checkOutput("stuckState", {29'd0, state}, 32'd0);
    checkOutput("stuckEn", {31'd0, en_clk_div8}, 32'd0);
`endif
    stuck = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
